// File: rtl/lm32_dp_ram_be_pkg.sv
// Shared helpers for the byte-enabled dual-port RAM.
// Lane geometry is computed here so every user derives it the same way.
package lm32_dp_ram_be_pkg;

    function automatic int unsigned lane_count(
        input int unsigned dw,
        input int unsigned bw
    );
        return dw / bw;
    endfunction

endpackage

// File: rtl/lm32_ram_clear_seq.sv
// Address walker for the post-reset zero-fill.
// Counts while enabled; done flags the last entry of the array.
module lm32_ram_clear_seq #(
    parameter int unsigned addr_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [addr_width-1:0] cnt,
    output logic                  done
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = &cnt;

endmodule

// File: rtl/lm32_dp_ram_be.sv
// Simple dual-port RAM with per-lane write enables and a registered read.
// Optionally zero-fills the whole array after reset before accepting traffic.
module lm32_dp_ram_be
    import lm32_dp_ram_be_pkg::*;
#(
    parameter int unsigned data_width     = 32,
    parameter int unsigned addr_width     = 8,
    parameter int unsigned byte_width     = 8,
    parameter bit          bypass         = 1'b0,
    parameter bit          clear_on_reset = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [data_width/byte_width-1:0] be_i,
    input  logic [addr_width-1:0] waddr_i,
    input  logic [data_width-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [addr_width-1:0] raddr_i,
    output logic [data_width-1:0] rdata_o,
    output logic                  busy_o
);

    localparam int unsigned lanes = lane_count(data_width, byte_width);
    localparam int unsigned depth = 2 ** addr_width;

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_READY = 1'b1;

    logic                  state;
    logic [addr_width-1:0] clr_cnt;
    logic                  clr_done;
    logic                  clearing;

    logic [lanes-1:0]      wr_lane;
    logic [addr_width-1:0] wr_addr;
    logic [data_width-1:0] wr_data;
    logic [data_width-1:0] rd_next;

    logic [data_width-1:0] mem [depth];

    assign clearing = (state == ST_CLEAR);
    assign busy_o   = clearing;

    lm32_ram_clear_seq #(
        .addr_width (addr_width)
    ) u_clear_seq (
        .clk  (clk_i),
        .rst  (rst_i),
        .en   (clearing),
        .cnt  (clr_cnt),
        .done (clr_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= clear_on_reset ? ST_CLEAR : ST_READY;
        end else if (clearing && clr_done) begin
            state <= ST_READY;
        end
    end

    // The clear sequence owns the write port; user writes are dropped under reset.
    always_comb begin
        wr_lane = '0;
        wr_addr = waddr_i;
        wr_data = wdata_i;
        if (rst_i) begin
            wr_lane = '0;
        end else if (clearing) begin
            wr_lane = '1;
            wr_addr = clr_cnt;
            wr_data = '0;
        end else if (we_i) begin
            wr_lane = be_i;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < lanes; k++) begin
            if (wr_lane[k]) begin
                mem[wr_addr][k*byte_width +: byte_width] <=
                    wr_data[k*byte_width +: byte_width];
            end
        end
    end

    always_comb begin
        rd_next = mem[raddr_i];
        if (bypass && we_i && (waddr_i == raddr_i)) begin
            for (int k = 0; k < lanes; k++) begin
                if (be_i[k]) begin
                    rd_next[k*byte_width +: byte_width] =
                        wdata_i[k*byte_width +: byte_width];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clearing) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= rd_next;
        end
    end

endmodule
